bytewrite_ram_tdp: RTL



---
 rtl/bytewrite_ram_pkg.sv | 32 +++
 rtl/bytewrite_ram_port_out.sv | 108 ++++++++++
 rtl/bytewrite_ram_tdp.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bytewrite_ram_pkg.sv
// -----------------------------------------------------------------------------
// bytewrite_ram_pkg
// Shared definitions for the true-dual-port byte-write RAM:
//   - write_mode_e : per-port read behaviour on its own write
//   - calc_dw      : word width from column count and column width
//   - clog2_f      : address-width helper used for elaboration checks
// -----------------------------------------------------------------------------
package bytewrite_ram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } write_mode_e;

  localparam int WRITE_MODE_MAX = 2;

  function automatic int calc_dw(input int nb_col, input int col_width);
    return nb_col * col_width;
  endfunction

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((r < 31) && ((1 << r) < n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bytewrite_ram_port_out.sv
// -----------------------------------------------------------------------------
// bytewrite_ram_port_out
// Output side of one RAM port: write-mode data selection, the read latch,
// an optional second pipeline register, read-valid tracking and the
// synchronous output reset.
//
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (output data -> RST_VAL, valid -> 0)
//   en_i   : port access this cycle
//   we_i   : column write enables of this access
//   oor_i  : address is outside the array
//   di_i   : write data of this access
//   rd_i   : stored word at the port address before this edge's writes
//   do_o   : read data
//   val_o  : read data valid
// -----------------------------------------------------------------------------
module bytewrite_ram_port_out
  import bytewrite_ram_pkg::*;
#(
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 9,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0,
  parameter logic [calc_dw(NB_COL, COL_WIDTH)-1:0] RST_VAL = '0,
  localparam int DW = calc_dw(NB_COL, COL_WIDTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NB_COL-1:0] we_i,
  input  logic              oor_i,
  input  logic [DW-1:0]     di_i,
  input  logic [DW-1:0]     rd_i,
  output logic [DW-1:0]     do_o,
  output logic              val_o
);

  localparam logic [1:0] MODE = WRITE_MODE[1:0];

  // Own-port view of the word after this access: written columns show the
  // new data, untouched columns keep the stored contents.
  logic [DW-1:0] merged;

  for (genvar c = 0; c < NB_COL; c++) begin : g_merge
    assign merged[c*COL_WIDTH +: COL_WIDTH] =
      we_i[c] ? di_i[c*COL_WIDTH +: COL_WIDTH] : rd_i[c*COL_WIDTH +: COL_WIDTH];
  end

  logic          load_p0;
  logic [DW-1:0] word_p0;
  logic [DW-1:0] dout_p0_d, dout_p0_q;
  logic          vld_p0_d, vld_p0_q;

  always_comb begin
    word_p0 = rd_i;
    if (MODE == WRITE_FIRST) begin
      word_p0 = merged;
    end
    if (oor_i) begin
      word_p0 = RST_VAL;
    end
    // In no-change mode a writing access leaves the output untouched.
    load_p0   = en_i && !((MODE == NO_CHANGE) && (|we_i));
    vld_p0_d  = load_p0;
    dout_p0_d = load_p0 ? word_p0 : dout_p0_q;
  end

  // ---- stage p0: read latch ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_p0_q <= RST_VAL;
      vld_p0_q  <= 1'b0;
    end else begin
      dout_p0_q <= dout_p0_d;
      vld_p0_q  <= vld_p0_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] dout_p1_d, dout_p1_q;
    logic          vld_p1_d, vld_p1_q;

    // Only valid data advances, so the output holds across idle cycles.
    always_comb begin
      vld_p1_d  = vld_p0_q;
      dout_p1_d = vld_p0_q ? dout_p0_q : dout_p1_q;
    end

    // ---- stage p1: output pipeline register ----
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dout_p1_q <= RST_VAL;
        vld_p1_q  <= 1'b0;
      end else begin
        dout_p1_q <= dout_p1_d;
        vld_p1_q  <= vld_p1_d;
      end
    end

    assign do_o  = dout_p1_q;
    assign val_o = vld_p1_q;
  end else begin : g_no_out_reg
    assign do_o  = dout_p0_q;
    assign val_o = vld_p0_q;
  end

endmodule

// File: rtl/bytewrite_ram_tdp.sv
// -----------------------------------------------------------------------------
// bytewrite_ram_tdp
// True-dual-port RAM with per-column write enables, one clock for both ports.
// The array is stored column by column so each column is an independent
// memory with its own write enables. On a same-address write collision
// port A owns every column it writes; port B only lands in the rest.
//
// Ports (A shown, B identical):
//   clk    : clock for both ports
//   rst    : synchronous active-high reset of output registers and valids;
//            memory contents and same-cycle writes are unaffected
//   ena    : port access enable
//   wea    : column write enables (bit i -> dia[i*COL_WIDTH +: COL_WIDTH])
//   addra  : word address; addresses >= SIZE ignore writes, read RST_VAL
//   dia    : write data
//   doa    : read data (latency 1, or 2 with OUT_REG)
//   vala   : read data valid
// -----------------------------------------------------------------------------
module bytewrite_ram_tdp
  import bytewrite_ram_pkg::*;
#(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 9,
  parameter int NB_COL     = 4,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0,
  parameter logic [calc_dw(NB_COL, COL_WIDTH)-1:0] RST_VAL = '0,
  localparam int DW = calc_dw(NB_COL, COL_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NB_COL-1:0]     wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DW-1:0]         dia,
  output logic [DW-1:0]         doa,
  output logic                  vala,
  input  logic                  enb,
  input  logic [NB_COL-1:0]     web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DW-1:0]         dib,
  output logic [DW-1:0]         dob,
  output logic                  valb
);

  if (clog2_f(SIZE) > ADDR_WIDTH) begin : g_bad_addr_width
    $error("bytewrite_ram_tdp: ADDR_WIDTH too small to address SIZE words");
  end
  if ((WRITE_MODE < 0) || (WRITE_MODE > WRITE_MODE_MAX)) begin : g_bad_write_mode
    $error("bytewrite_ram_tdp: unsupported WRITE_MODE");
  end

  // One extra bit so SIZE == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH + 1)'(SIZE);

  logic          a_in_range, b_in_range, same_addr;
  logic [DW-1:0] rda_word, rdb_word;

  assign a_in_range = ({1'b0, addra} < SIZE_L);
  assign b_in_range = ({1'b0, addrb} < SIZE_L);
  assign same_addr  = (addra == addrb);

  for (genvar c = 0; c < NB_COL; c++) begin : g_col
    logic [COL_WIDTH-1:0] mem_q [SIZE];
    logic                 wr_a, wr_b;

    assign wr_a = ena && wea[c] && a_in_range;
    // B yields any column A is writing at the same address.
    assign wr_b = enb && web[c] && b_in_range && !(wr_a && same_addr);

    // ---- memory array write ----
    always_ff @(posedge clk) begin
      if (wr_a) begin
        mem_q[addra] <= dia[c*COL_WIDTH +: COL_WIDTH];
      end
      if (wr_b) begin
        mem_q[addrb] <= dib[c*COL_WIDTH +: COL_WIDTH];
      end
    end

    // Pre-write contents; both ports latch these at the edge, which is what
    // makes a cross-port read during a write return the old word.
    assign rda_word[c*COL_WIDTH +: COL_WIDTH] = mem_q[addra];
    assign rdb_word[c*COL_WIDTH +: COL_WIDTH] = mem_q[addrb];
  end

  bytewrite_ram_port_out #(
    .NB_COL     (NB_COL),
    .COL_WIDTH  (COL_WIDTH),
    .WRITE_MODE (WRITE_MODE),
    .OUT_REG    (OUT_REG),
    .RST_VAL    (RST_VAL)
  ) u_out_a (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (ena),
    .we_i  (wea),
    .oor_i (!a_in_range),
    .di_i  (dia),
    .rd_i  (rda_word),
    .do_o  (doa),
    .val_o (vala)
  );

  bytewrite_ram_port_out #(
    .NB_COL     (NB_COL),
    .COL_WIDTH  (COL_WIDTH),
    .WRITE_MODE (WRITE_MODE),
    .OUT_REG    (OUT_REG),
    .RST_VAL    (RST_VAL)
  ) u_out_b (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (enb),
    .we_i  (web),
    .oor_i (!b_in_range),
    .di_i  (dib),
    .rd_i  (rdb_word),
    .do_o  (dob),
    .val_o (valb)
  );

endmodule
